// File: rtl/tlp_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlp_arb_pkg
// Description : Shared types and constants for the TLP virtual-channel arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package tlp_arb_pkg;

  localparam int NUM_VC = 4;
  localparam int VC_W   = 2;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERROR  = 2'd3
  } arb_state_t;

  function automatic logic [NUM_VC-1:0] vc_onehot(input logic [VC_W-1:0] idx);
    return NUM_VC'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Wrap-around priority search over the eligible channels.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import tlp_arb_pkg::*;
(
  input  logic [NUM_VC-1:0] eligible,
  input  logic [VC_W-1:0]   start,
  output logic [NUM_VC-1:0] pick,
  output logic [VC_W-1:0]   idx,
  output logic              any
);

  logic [VC_W-1:0] w_cand;

  always_comb begin
    w_cand = '0;
    idx    = start;
    any    = 1'b0;
    // Index arithmetic is VC_W wide, so the search wraps 3 -> 0 naturally.
    for (int k = 0; k < NUM_VC; k++) begin
      w_cand = start + VC_W'(k);
      if (!any && eligible[w_cand]) begin
        any = 1'b1;
        idx = w_cand;
      end
    end
    pick = vc_onehot(idx) & {NUM_VC{any}};
  end

endmodule
`default_nettype wire

// File: rtl/tlp_vc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tlp_vc_arbiter
// Description : Round-robin, burst-limited scheduler of four VC FIFOs onto one link.
// Revision    : 1.0 - initial release
// ============================================================================
module tlp_vc_arbiter
  import tlp_arb_pkg::*;
#(
  parameter int READ_LAT  = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [NUM_VC-1:0] src_empty,
  input  logic [NUM_VC-1:0] dst_pause,
  input  logic [NUM_VC-1:0] fifo_error,
  output logic [NUM_VC-1:0] pop,
  output logic [VC_W-1:0]   grant_vc,
  output logic              data_valid,
  output logic [VC_W-1:0]   data_vc,
  output logic              idle,
  output logic              error,
  output logic [NUM_VC-1:0] error_vc
);

  localparam logic [3:0] c_burst_lim = 4'(MAX_BURST - 1);

  arb_state_t                r_state;
  logic [VC_W-1:0]           r_rr_ptr;
  logic [VC_W-1:0]           r_last_vc;
  logic                      r_have_last;
  logic [3:0]                r_burst_cnt;
  logic [NUM_VC-1:0]         r_error_vc;
  logic [READ_LAT-1:0]       r_pipe_v;
  logic [READ_LAT*VC_W-1:0]  r_pipe_vc;

  logic [NUM_VC-1:0]         w_eligible;
  logic [VC_W-1:0]           w_rr_start;
  logic [NUM_VC-1:0]         w_rr_pick;
  logic [VC_W-1:0]           w_rr_idx;
  logic                      w_rr_any;
  logic                      w_cont;
  logic                      w_can_pop;
  logic [VC_W-1:0]           w_sel_idx;
  logic [READ_LAT-1:0]       w_pipe_v_nxt;
  logic [READ_LAT*VC_W-1:0]  w_pipe_vc_nxt;

  assign w_eligible = ~src_empty & ~dst_pause;
  assign w_rr_start = r_rr_ptr + VC_W'(1);

  rr_pick u_rr_pick (
    .eligible (w_eligible),
    .start    (w_rr_start),
    .pick     (w_rr_pick),
    .idx      (w_rr_idx),
    .any      (w_rr_any)
  );

  // No channel counts as "last granted" until the first grant after reset/init.
  assign w_cont    = r_have_last && w_eligible[r_last_vc] && (r_burst_cnt < c_burst_lim);
  assign w_can_pop = ((r_state == ST_IDLE) || (r_state == ST_ACTIVE)) &&
                     !init && (fifo_error == '0) && w_rr_any;
  assign w_sel_idx = w_cont ? r_last_vc : w_rr_idx;

  assign pop      = w_can_pop ? (w_cont ? vc_onehot(r_last_vc) : w_rr_pick) : '0;
  assign grant_vc = w_can_pop ? w_sel_idx : r_last_vc;

  generate
    if (READ_LAT == 1) begin : g_pipe_one
      assign w_pipe_v_nxt  = w_can_pop;
      assign w_pipe_vc_nxt = grant_vc;
    end else begin : g_pipe_multi
      assign w_pipe_v_nxt  = {r_pipe_v[READ_LAT-2:0], w_can_pop};
      assign w_pipe_vc_nxt = {r_pipe_vc[(READ_LAT-1)*VC_W-1:0], grant_vc};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_INIT;
      r_rr_ptr    <= VC_W'(NUM_VC - 1);
      r_last_vc   <= '0;
      r_have_last <= 1'b0;
      r_burst_cnt <= '0;
      r_error_vc  <= '0;
      r_pipe_v    <= '0;
      r_pipe_vc   <= '0;
    end else if (init) begin
      r_state     <= ST_INIT;
      r_rr_ptr    <= VC_W'(NUM_VC - 1);
      r_have_last <= 1'b0;
      r_burst_cnt <= '0;
      r_error_vc  <= '0;
      r_pipe_v    <= '0;
      r_pipe_vc   <= '0;
    end else begin
      // In-flight words keep draining in every state, including ERROR.
      r_pipe_v  <= w_pipe_v_nxt;
      r_pipe_vc <= w_pipe_vc_nxt;

      case (r_state)
        ST_INIT: begin
          if (fifo_error == '0) r_state <= ST_IDLE;
        end
        ST_IDLE, ST_ACTIVE: begin
          if (fifo_error != '0) begin
            r_state    <= ST_ERROR;
            r_error_vc <= fifo_error;
          end else if (w_can_pop) begin
            r_state <= ST_ACTIVE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_ERROR;
      endcase

      if (w_can_pop) begin
        r_last_vc   <= w_sel_idx;
        r_have_last <= 1'b1;
        if (w_cont) begin
          r_burst_cnt <= r_burst_cnt + 4'd1;
        end else begin
          r_burst_cnt <= '0;
          r_rr_ptr    <= w_rr_idx;
        end
      end else begin
        r_burst_cnt <= '0;
      end
    end
  end

  assign data_valid = r_pipe_v[READ_LAT-1];
  assign data_vc    = r_pipe_vc[READ_LAT*VC_W-1 -: VC_W];
  assign idle       = (r_state == ST_IDLE);
  assign error      = (r_state == ST_ERROR);
  assign error_vc   = r_error_vc;

endmodule
`default_nettype wire

// File: tb/tb_tlp_vc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlp_vc_arbiter
// Description : Directed self-checking bench for tlp_vc_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlp_vc_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [3:0] src_empty;
  logic [3:0] dst_pause;
  logic [3:0] fifo_error;

  logic [3:0] b1_pop, b4_pop, l3_pop;
  logic [1:0] b1_gvc, b4_gvc, l3_gvc;
  logic       b1_dv, b4_dv, l3_dv;
  logic [1:0] b1_dvc, b4_dvc, l3_dvc;
  logic       b1_idle, b4_idle, l3_idle;
  logic       b1_err, b4_err, l3_err;
  logic [3:0] b1_evc, b4_evc, l3_evc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tlp_vc_arbiter #(.READ_LAT(1), .MAX_BURST(1)) u_b1 (
    .clk(clk), .reset(reset), .init(init), .src_empty(src_empty),
    .dst_pause(dst_pause), .fifo_error(fifo_error), .pop(b1_pop),
    .grant_vc(b1_gvc), .data_valid(b1_dv), .data_vc(b1_dvc),
    .idle(b1_idle), .error(b1_err), .error_vc(b1_evc));

  tlp_vc_arbiter #(.READ_LAT(1), .MAX_BURST(4)) u_b4 (
    .clk(clk), .reset(reset), .init(init), .src_empty(src_empty),
    .dst_pause(dst_pause), .fifo_error(fifo_error), .pop(b4_pop),
    .grant_vc(b4_gvc), .data_valid(b4_dv), .data_vc(b4_dvc),
    .idle(b4_idle), .error(b4_err), .error_vc(b4_evc));

  tlp_vc_arbiter #(.READ_LAT(3), .MAX_BURST(4)) u_l3 (
    .clk(clk), .reset(reset), .init(init), .src_empty(src_empty),
    .dst_pause(dst_pause), .fifo_error(fifo_error), .pop(l3_pop),
    .grant_vc(l3_gvc), .data_valid(l3_dv), .data_vc(l3_dvc),
    .idle(l3_idle), .error(l3_err), .error_vc(l3_evc));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_pulse();
    tick();
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] burst_exp [10];
    burst_exp = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};

    reset = 1'b0; init = 1'b0;
    src_empty = 4'b1111; dst_pause = 4'b0000; fifo_error = 4'b0000;

    // Reset values, then init sequencing
    #2;
    check_eq("rst_pop", b4_pop, 4'b0000);
    check_eq("rst_gvc", b4_gvc, 2'd0);
    check_eq("rst_dv", b4_dv, 1'b0);
    check_eq("rst_dvc", b4_dvc, 2'd0);
    check_eq("rst_idle", b4_idle, 1'b0);
    check_eq("rst_err", b4_err, 1'b0);
    check_eq("rst_evc", b4_evc, 4'b0000);
    check_eq("rst_b1_err", b1_err, 1'b0);
    check_eq("rst_b1_evc", b1_evc, 4'b0000);
    check_eq("rst_l3_dvc", l3_dvc, 2'd0);
    check_eq("rst_l3_evc", l3_evc, 4'b0000);
    repeat (3) tick();
    check_eq("rst_clk_idle", b4_idle, 1'b0);
    reset = 1'b1; init = 1'b1;
    tick(); #1;
    check_eq("init_idle0", b4_idle, 1'b0);
    check_eq("init_pop0", b4_pop, 4'b0000);
    tick(); #1;
    check_eq("init_idle1", b4_idle, 1'b0);
    init = 1'b0; #1;
    check_eq("init_fall_idle", b4_idle, 1'b0);
    tick(); #1;
    check_eq("idle_after_init", b4_idle, 1'b1);
    check_eq("idle_pop", b4_pop, 4'b0000);
    check_eq("idle_err", b4_err, 1'b0);
    tick(); #1;
    check_eq("idle_hold", b4_idle, 1'b1);
    check_eq("idle_dv", b4_dv, 1'b0);

    // All four eligible: strict rotation with MAX_BURST=1, bursts of 4 otherwise
    src_empty = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      #1;
      if (k == 0) check_eq("rr_idle_while_pop", b1_idle, 1'b1);
      check_eq("rr_b1_gvc", b1_gvc, 32'(k % 4));
      check_eq("rr_b1_pop", b1_pop, 32'(1 << (k % 4)));
      if (k > 0) begin
        check_eq("rr_b1_dv", b1_dv, 1'b1);
        check_eq("rr_b1_dvc", b1_dvc, 32'((k - 1) % 4));
      end
      check_eq("rr_b4_gvc", b4_gvc, (k < 4) ? 32'd0 : 32'd1);
    end

    // Bursts between VC1 and VC2, then VC1 runs dry mid-burst
    tick();
    init = 1'b1;
    tick(); #1;
    check_eq("flush_idle", b4_idle, 1'b0);
    check_eq("flush_pop", b4_pop, 4'b0000);
    check_eq("flush_dv", b1_dv, 1'b0);
    init = 1'b0;
    src_empty = 4'b1001;
    tick();
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      #1;
      check_eq("burst_gvc", b4_gvc, burst_exp[k]);
      check_eq("burst_pop", b4_pop, 32'(1 << burst_exp[k]));
    end
    tick();
    src_empty = 4'b1011; #1;
    check_eq("drain_switch_gvc", b4_gvc, 2'd2);
    check_eq("drain_switch_pop", b4_pop, 4'b0100);
    tick(); #1;
    check_eq("drain_cont_gvc", b4_gvc, 2'd2);
    check_eq("drain_cont_dvc", b4_dvc, 2'd2);

    // Pause handling
    init_pulse();
    src_empty = 4'b0110; dst_pause = 4'b0000;
    tick(); #1;
    check_eq("pause_first_pop", b4_pop, 4'b0001);
    tick();
    dst_pause = 4'b0001; #1;
    check_eq("pause_same_cycle_pop", b4_pop, 4'b1000);
    check_eq("pause_same_cycle_gvc", b4_gvc, 2'd3);
    tick();
    dst_pause = 4'b1001; #1;
    check_eq("pause_all_pop", b4_pop, 4'b0000);
    check_eq("pause_gvc_hold", b4_gvc, 2'd3);
    check_eq("pause_still_active", b4_idle, 1'b0);
    tick(); #1;
    check_eq("pause_to_idle", b4_idle, 1'b1);
    src_empty = 4'b1101; dst_pause = 4'b0010; #1;
    check_eq("simul_pop", b4_pop, 4'b0000);
    tick(); #1;
    check_eq("simul_idle", b4_idle, 1'b1);

    // Error entry, drain of in-flight words, recovery through init
    src_empty = 4'b0000; dst_pause = 4'b0000; #1;
    check_eq("err_pre_gvc", b4_gvc, 2'd3);
    check_eq("err_pre_pop", b4_pop, 4'b1000);
    tick();
    fifo_error = 4'b0100; #1;
    check_eq("err_cycle_pop", b4_pop, 4'b0000);
    check_eq("err_cycle_l3_pop", l3_pop, 4'b0000);
    tick();
    fifo_error = 4'b0000; #1;
    check_eq("err_flag", b4_err, 1'b1);
    check_eq("err_vc", b4_evc, 4'b0100);
    check_eq("err_pop", b4_pop, 4'b0000);
    check_eq("err_not_idle", b4_idle, 1'b0);
    tick(); #1;
    check_eq("err_drain_dv", l3_dv, 1'b1);
    check_eq("err_drain_dvc", l3_dvc, 2'd3);
    check_eq("err_l3_flag", l3_err, 1'b1);
    check_eq("err_hold_pop", b4_pop, 4'b0000);
    tick(); #1;
    check_eq("err_drained_dv", l3_dv, 1'b0);
    init = 1'b1;
    tick(); #1;
    check_eq("err_init_err", b4_err, 1'b0);
    check_eq("err_init_idle", b4_idle, 1'b0);
    check_eq("err_init_evc", b4_evc, 4'b0000);
    check_eq("err_init_pop", b4_pop, 4'b0000);
    init = 1'b0;
    tick(); #1;
    check_eq("recover_idle", b4_idle, 1'b1);
    check_eq("recover_err", b4_err, 1'b0);
    check_eq("recover_pop", b4_pop, 4'b0001);

    // Async reset between edges with READ_LAT=3 words in flight
    check_eq("async_pre_l3_pop", l3_pop, 4'b0001);
    repeat (3) tick();
    #1;
    check_eq("async_inflight_dv", l3_dv, 1'b1);
    check_eq("async_inflight_dvc", l3_dvc, 2'd0);
    #2;
    reset = 1'b0; #1;
    check_eq("async_pop", l3_pop, 4'b0000);
    check_eq("async_dv", l3_dv, 1'b0);
    check_eq("async_idle", l3_idle, 1'b0);
    check_eq("async_gvc", l3_gvc, 2'd0);
    check_eq("async_b4_pop", b4_pop, 4'b0000);
    #1;
    reset = 1'b1; #1;
    check_eq("async_rel_pop", l3_pop, 4'b0000);
    tick(); #1;
    check_eq("async_after_idle", l3_idle, 1'b1);
    check_eq("async_after_pop", l3_pop, 4'b0001);
    check_eq("async_after_gvc", l3_gvc, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
